uart_cfg_core: RTL
==================

Name: uart_cfg_core

Overview:
- Next-generation 8N1 UART pair running entirely on the system clock `hclk`.
- Baud-tick generation is internal: a 16x oversampling enable, not a divided clock.
- Frame format is set by parameters: data bits 5..9, parity none/odd/even, 1 or 2 stop bits.
- RX adds mid-bit sampling, false-start rejection, and parity/framing error flags. Sits between the board-level top and the rx/tx pins.

Parameters:
- CLK_FREQ, 12000000: `hclk` frequency in Hz.
- BAUD, 9600: line rate in bit/s.
- DATA_BITS, 8: payload width, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2 (TX sends this many stop bits; RX checks only the first).

Ports:
- hclk  in  1  system clock, all logic on its rising edge
- rst  in  1  synchronous reset, active-high
- rx  in  1  serial receive line, asynchronous, idle high
- tx  out  1  serial transmit line, idle high
- tx_data  in  DATA_BITS  word to transmit
- tx_start  in  1  request transmit, sampled when tx_busy=0
- tx_busy  out  1  transmitter frame in progress
- rx_data  out  DATA_BITS  last received word
- rx_valid  out  1  one-cycle pulse, rx_data updated
- rx_parity_err  out  1  parity mismatch on the word flagged by rx_valid
- rx_frame_err  out  1  stop bit sampled low on the word flagged by rx_valid

Behaviour:
- Clocking and reset: one clock `hclk`; reset is synchronous and active-high on `rst`.
- Reset values: tx=1, tx_busy=0, rx_data=0, rx_valid=0, both error flags=0. All counters and FSMs go to IDLE.
- Reset asserted mid-frame aborts the frame immediately: tx returns high on the next edge and no rx_valid is produced.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD*16), integer division, minimum 1.
  - Counter 0..DIV-1; tick=1 for one hclk when the counter equals DIV-1, then the counter wraps to 0.
  - Free-running; cleared only by rst.
- Bit period: 16 ticks. TX and RX share the tick.
- TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
  - IDLE: tx_start=1 latches tx_data into a shift register and sets tx_busy=1 on the next edge.
  - The start bit begins at the next tick.
  - tx_start while tx_busy=1 is ignored; no queuing.
  - Data is shifted out LSB first, DATA_BITS bits.
  - Parity bit: even parity = XOR of the data bits; odd parity = its inverse.
  - STOP holds tx=1 for STOP_BITS*16 ticks. tx_busy falls in the same cycle the last stop tick completes.
  - A tx_start in that cycle is not accepted; it is accepted one cycle later.
- RX synchroniser: 2-flop synchroniser on rx, reset value 1. The FSM sees only the synchronised value.
- RX FSM: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: a synchronised low starts a tick counter at 0.
  - START: resample at tick 7. If high, it is a false start: return to IDLE with no output.
  - Every following bit is sampled 16 ticks after the previous sample, i.e. at bit mid-point. Data is assembled LSB first.
  - STOP: sample the stop bit. On that same edge:
    - rx_data <= word;
    - rx_valid = 1 for exactly one hclk;
    - rx_parity_err = computed parity != received parity (0 if PARITY=0);
    - rx_frame_err = !stop_sample.
  - The error flags hold until the next rx_valid or rst.
- After a framing error, RX waits for the synchronised line to be high before re-arming IDLE, so a break does not retrigger.
- RX and TX are fully independent; simultaneous activity is legal.

Optional Feature:
- Macro: UART_LOOPBACK_EN.
- Defined: adds input port `loopback` (1 bit). When loopback=1, the RX synchroniser input is driven from the internal tx signal instead of rx, and the tx pin is forced high.
- The loopback input is sampled combinationally; a mid-frame change yields undefined data but no lockup.
- Not defined: no loopback port; RX always uses rx.

Test Plan:
- Use CLK_FREQ=64000, BAUD=1000 (DIV=4, bit=64 hclk) unless stated.
- TX 8N1: tx_data=8'hA5, tx_start pulse → tx waveform 0,1,0,1,0,0,1,0,1,1, each 64 cycles; tx_busy high for 640 cycles, then low; second tx_start mid-frame ignored.
- RX 8E1: drive frame for 8'h3C with correct even parity (0) → one rx_valid pulse, rx_data=8'h3C, parity_err=0, frame_err=0; repeat with parity bit flipped → rx_data=8'h3C, parity_err=1.
- Framing/break: DATA_BITS=7, frame 7'h55 with stop bit 0, then line held low 500 cycles → rx_frame_err=1, exactly one rx_valid, no further rx_valid until the line returns high and a new frame arrives.
- False start: 20-cycle low glitch on rx → no rx_valid; a valid frame 8'h81 sent 100 cycles later is received correctly.
- Reset mid-frame: assert rst at cycle 300 of a TX frame and an RX frame → next edge tx=1, tx_busy=0, no rx_valid; a subsequent frame with 9 data bits (DATA_BITS=9, 9'h1FF, 2 stop bits) transmits 12 bit-times.
- Loopback (UART_LOOPBACK_EN, loopback=1): tx_start with 8'h5A → rx_valid with rx_data=8'h5A while the tx pin stays 1 throughout.

Source files
------------

// File: rtl/uart_cfg_core_if.sv
// rtl/uart_cfg_core_if.sv - transmit/receive word handshake bundle for uart_cfg_core
//
// Purpose: groups the parallel-side signals of the UART.
//   tx_data/tx_start   : word and request toward the transmitter
//   tx_busy            : transmitter frame in progress
//   rx_data/rx_valid   : last received word and its one-cycle strobe
//   rx_parity_err      : parity mismatch on the word flagged by rx_valid
//   rx_frame_err       : stop bit sampled low on the word flagged by rx_valid
// Modports: slave = UART core side, master = user side.

interface uart_cfg_core_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 tx_busy;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;

    modport slave (
        input  tx_data, tx_start,
        output tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport master (
        output tx_data, tx_start,
        input  tx_busy, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_cfg_core.sv
// rtl/uart_cfg_core.sv - parameterised UART transmitter/receiver on a 16x tick enable
//
// Purpose: UART pair running on hclk with an internal 16x oversampling tick.
//   Frame: start, DATA_BITS (5..9) LSB first, optional parity, STOP_BITS stop bits.
// Ports:
//   hclk     : system clock, rising edge
//   rst      : synchronous active-high reset
//   rx       : serial input (asynchronous, idle high)
//   tx       : serial output (idle high)
//   bus      : uart_cfg_core_if.slave word handshake
//   loopback : only with UART_LOOPBACK_EN defined; routes internal tx to the
//              receiver and holds the tx pin high
// Optional feature macro: UART_LOOPBACK_EN

module uart_cfg_core #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic            hclk,
    input  logic            rst,
    input  logic            rx,
    output logic            tx,
    uart_cfg_core_if.slave  bus
`ifdef UART_LOOPBACK_EN
    ,
    input  logic            loopback
`endif
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY != 0);
    localparam logic          PAR_ODD   = (PARITY == 1);

    // ---------------- tick generator ----------------
    logic [CW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    always_ff @(posedge hclk) begin
        if (rst || tick) div_q <= '0;
        else             div_q <= div_q + 1'b1;
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    tx_state_t            tx_st_q;
    logic [DATA_BITS-1:0] tx_sh_q;
    logic                 tx_par_q;
    logic                 tx_q;
    logic                 tx_busy_q;
    logic [3:0]           tx_tcnt_q;
    logic [3:0]           tx_bit_q;

    // Every bit state advances on the tick where the 4-bit tick count is 15;
    // the counter wraps to 0 by itself so the next bit starts cleanly.
    always_ff @(posedge hclk) begin
        if (rst) begin
            tx_st_q   <= TX_IDLE;
            tx_sh_q   <= '0;
            tx_par_q  <= 1'b0;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            tx_tcnt_q <= '0;
            tx_bit_q  <= '0;
        end else begin
            case (tx_st_q)
                TX_IDLE: begin
                    if (bus.tx_start) begin
                        tx_sh_q   <= bus.tx_data;
                        tx_par_q  <= PAR_ODD ? ~^bus.tx_data : ^bus.tx_data;
                        tx_busy_q <= 1'b1;
                        tx_st_q   <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (tick) begin
                        tx_q      <= 1'b0;
                        tx_tcnt_q <= '0;
                        tx_st_q   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 4'd1;
                        if (tx_tcnt_q == 4'd15) begin
                            tx_q     <= tx_sh_q[0];
                            tx_sh_q  <= tx_sh_q >> 1;
                            tx_bit_q <= '0;
                            tx_st_q  <= TX_DATA;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 4'd1;
                        if (tx_tcnt_q == 4'd15) begin
                            if (tx_bit_q == LAST_DATA) begin
                                tx_bit_q <= '0;
                                if (PAR_EN) begin
                                    tx_q    <= tx_par_q;
                                    tx_st_q <= TX_PAR;
                                end else begin
                                    tx_q    <= 1'b1;
                                    tx_st_q <= TX_STOP;
                                end
                            end else begin
                                tx_q     <= tx_sh_q[0];
                                tx_sh_q  <= tx_sh_q >> 1;
                                tx_bit_q <= tx_bit_q + 4'd1;
                            end
                        end
                    end
                end
                TX_PAR: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 4'd1;
                        if (tx_tcnt_q == 4'd15) begin
                            tx_q     <= 1'b1;
                            tx_bit_q <= '0;
                            tx_st_q  <= TX_STOP;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        tx_tcnt_q <= tx_tcnt_q + 4'd1;
                        if (tx_tcnt_q == 4'd15) begin
                            if (tx_bit_q == LAST_STOP) begin
                                tx_busy_q <= 1'b0;
                                tx_st_q   <= TX_IDLE;
                            end else begin
                                tx_bit_q <= tx_bit_q + 4'd1;
                            end
                        end
                    end
                end
                default: tx_st_q <= TX_IDLE;
            endcase
        end
    end

    // ---------------- line routing ----------------
    logic rx_in;
`ifdef UART_LOOPBACK_EN
    assign rx_in = loopback ? tx_q : rx;
    assign tx    = loopback ? 1'b1 : tx_q;
`else
    assign rx_in = rx;
    assign tx    = tx_q;
`endif

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_t;

    logic                 rx_s1_q, rx_s2_q;
    rx_state_t            rx_st_q;
    logic [3:0]           rx_tcnt_q;
    logic [3:0]           rx_bit_q;
    logic [DATA_BITS-1:0] rx_sh_q;
    logic                 rx_pbit_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_perr_q;
    logic                 rx_ferr_q;
    logic                 rx_par_calc;

    assign rx_par_calc = PAR_ODD ? ~^rx_sh_q : ^rx_sh_q;

    always_ff @(posedge hclk) begin
        if (rst) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx_in;
            rx_s2_q <= rx_s1_q;
        end
    end

    // START samples after 8 ticks (mid start bit); every later sample is 16
    // ticks after the previous one, landing on bit mid-points.
    always_ff @(posedge hclk) begin
        if (rst) begin
            rx_st_q    <= RX_IDLE;
            rx_tcnt_q  <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            rx_pbit_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (rx_st_q)
                RX_IDLE: begin
                    if (!rx_s2_q) begin
                        rx_tcnt_q <= '0;
                        rx_st_q   <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tcnt_q == 4'd7) begin
                            rx_tcnt_q <= '0;
                            rx_bit_q  <= '0;
                            if (rx_s2_q) rx_st_q <= RX_IDLE;
                            else         rx_st_q <= RX_DATA;
                        end else begin
                            rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                            if (rx_bit_q == LAST_DATA) begin
                                if (PAR_EN) rx_st_q <= RX_PAR;
                                else        rx_st_q <= RX_STOP;
                            end else begin
                                rx_bit_q <= rx_bit_q + 4'd1;
                            end
                        end
                    end
                end
                RX_PAR: begin
                    if (tick) begin
                        rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_pbit_q <= rx_s2_q;
                            rx_st_q   <= RX_STOP;
                        end
                    end
                end
                RX_STOP: begin
                    if (tick) begin
                        rx_tcnt_q <= rx_tcnt_q + 4'd1;
                        if (rx_tcnt_q == 4'd15) begin
                            rx_data_q  <= rx_sh_q;
                            rx_valid_q <= 1'b1;
                            rx_perr_q  <= PAR_EN && (rx_par_calc != rx_pbit_q);
                            rx_ferr_q  <= !rx_s2_q;
                            // a low stop bit may be a break: hold off until the line idles
                            if (rx_s2_q) rx_st_q <= RX_IDLE;
                            else         rx_st_q <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s2_q) rx_st_q <= RX_IDLE;
                end
                default: rx_st_q <= RX_IDLE;
            endcase
        end
    end

    assign bus.tx_busy       = tx_busy_q;
    assign bus.rx_data       = rx_data_q;
    assign bus.rx_valid      = rx_valid_q;
    assign bus.rx_parity_err = rx_perr_q;
    assign bus.rx_frame_err  = rx_ferr_q;

endmodule
